// File: rtl/csr_exec_unit_pkg.sv
// csr_exec_unit_pkg: shared Conf encodings and FSM state type for the CSR execution unit
package csr_exec_unit_pkg;
  localparam logic [3:0] CSRRD_CONF = 4'd0;
  localparam logic [3:0] CSRWR_CONF = 4'd1;
  localparam logic [3:0] CSRXG_CONF = 4'd2;
  typedef enum logic [2:0] {IDLE, READ, WAIT_CMT, WRITE, BCAST} csr_exec_state_t;
endpackage

// File: rtl/csr_exec_unit_merge.sv
// csr_merge: CSR write-data select and write qualification from the Conf encoding
// conf in selects the operation; rd_val/rj_val/csr_old in are the operands;
// wr_en out is high only for write-capable encodings, wdata out is the merged value.
module csr_merge import csr_exec_unit_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        conf,
  input  logic [DATA_W-1:0] rd_val,
  input  logic [DATA_W-1:0] rj_val,
  input  logic [DATA_W-1:0] csr_old,
  output logic              wr_en,
  output logic [DATA_W-1:0] wdata
);
  always_comb begin
    wr_en = (conf == CSRWR_CONF) || (conf == CSRXG_CONF);
    wdata = (conf == CSRXG_CONF) ? ((rd_val & rj_val) | (csr_old & ~rj_val)) : rd_val;
  end
endmodule

// File: rtl/csr_exec_unit.sv
// csr_exec_unit: executes one csrrd/csrwr/csrxchg at a time, writes the CSR at ROB head, broadcasts the old value on CDB lane 4
// clk, rst (async active-low), flush: control; busy: issue-queue stall.
// *_awake: issued instruction; prf_*/csr_r*: operand reads; csr_we/waddr/wdata: CSR write;
// rob_head_*: commit check; *_cdb: registered CDB lane-4 broadcast.
module csr_exec_unit import csr_exec_unit_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int CSRA_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              busy,
  input  logic              ready_awake,
  input  logic [PREG_W-1:0] tag_rob_awake,
  input  logic [3:0]        Conf_awake,
  input  logic [PREG_W-1:0] Pj_awake,
  input  logic [PREG_W-1:0] Pd_old_awake,
  input  logic [PREG_W-1:0] Pd_awake,
  input  logic [CSRA_W-1:0] csr_addr_awake,
  input  logic              RegWr_awake,
  input  logic              csrWr_awake,
  output logic [PREG_W-1:0] prf_raddr_j,
  output logic [PREG_W-1:0] prf_raddr_d,
  input  logic [DATA_W-1:0] prf_rdata_j,
  input  logic [DATA_W-1:0] prf_rdata_d,
  output logic [CSRA_W-1:0] csr_raddr,
  input  logic [DATA_W-1:0] csr_rdata,
  output logic              csr_we,
  output logic [CSRA_W-1:0] csr_waddr,
  output logic [DATA_W-1:0] csr_wdata,
  input  logic              rob_head_valid,
  input  logic [PREG_W-1:0] rob_head_tag,
  output logic              ready_cdb,
  output logic              RegWr_cdb,
  output logic [PREG_W-1:0] Pd_cdb,
  output logic [PREG_W-1:0] tag_rob_cdb,
  output logic [DATA_W-1:0] data_cdb
);
  csr_exec_state_t state, next_state;
  logic [PREG_W-1:0] tag, pj, pd_old, pd;
  logic [3:0]        conf;
  logic [CSRA_W-1:0] csr_addr;
  logic              reg_wr, csr_wr, merge_we, to_bcast;
  logic [DATA_W-1:0] rj_val, rd_val, csr_old, merge_wdata;

  csr_merge #(.DATA_W(DATA_W)) u_merge (
    .conf    (conf),
    .rd_val  (rd_val),
    .rj_val  (rj_val),
    .csr_old (csr_old),
    .wr_en   (merge_we),
    .wdata   (merge_wdata)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next_state;

  always_comb
    next_state = flush ? IDLE :
                 (state == IDLE) ? (ready_awake ? READ : IDLE) :
                 (state == READ) ? WAIT_CMT :
                 (state == WAIT_CMT) ? ((rob_head_valid && rob_head_tag == tag) ? WRITE : WAIT_CMT) :
                 (state == WRITE) ? BCAST : IDLE;

  // flush in WRITE must kill both the CSR write and the broadcast that would follow
  always_comb begin
    busy        = state != IDLE;
    to_bcast    = (state == WRITE) && !flush;
    csr_we      = to_bcast && csr_wr && merge_we;
    csr_waddr   = csr_addr;
    csr_wdata   = merge_wdata;
    csr_raddr   = csr_addr;
    prf_raddr_j = pj;
    prf_raddr_d = pd_old;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) {tag, conf, pj, pd_old, pd, csr_addr, reg_wr, csr_wr, rj_val, rd_val, csr_old} <= '0;
    else if (flush) {tag, conf, pj, pd_old, pd, csr_addr, reg_wr, csr_wr, rj_val, rd_val, csr_old} <= '0;
    else begin
      if (state == IDLE && ready_awake)
        {tag, conf, pj, pd_old, pd, csr_addr, reg_wr, csr_wr} <=
          {tag_rob_awake, Conf_awake, Pj_awake, Pd_old_awake, Pd_awake, csr_addr_awake, RegWr_awake, csrWr_awake};
      if (state == READ) {rj_val, rd_val, csr_old} <= {prf_rdata_j, prf_rdata_d, csr_rdata};
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) {ready_cdb, RegWr_cdb, Pd_cdb, tag_rob_cdb, data_cdb} <= '0;
    else begin
      ready_cdb   <= to_bcast;
      RegWr_cdb   <= to_bcast && reg_wr;
      Pd_cdb      <= to_bcast ? pd : '0;
      tag_rob_cdb <= to_bcast ? tag : '0;
      data_cdb    <= to_bcast ? csr_old : '0;
    end

  a_no_awake_while_busy: assert property (@(posedge clk) disable iff (!rst) !(ready_awake && busy));
endmodule

// File: tb/tb_csr_exec_unit.sv
// tb_csr_exec_unit: table-driven scoreboard bench for csr_exec_unit
module tb_csr_exec_unit;
  logic        clk = 0, rst = 0, flush = 0, busy;
  logic        ready_awake = 0, RegWr_awake = 0, csrWr_awake = 0;
  logic [5:0]  tag_rob_awake = 0, Pj_awake = 0, Pd_old_awake = 0, Pd_awake = 0;
  logic [3:0]  Conf_awake = 0;
  logic [13:0] csr_addr_awake = 0;
  logic [5:0]  prf_raddr_j, prf_raddr_d;
  logic [31:0] prf_rdata_j, prf_rdata_d, csr_rdata, csr_wdata, data_cdb;
  logic [13:0] csr_raddr, csr_waddr;
  logic        csr_we, ready_cdb, RegWr_cdb;
  logic        rob_head_valid = 0;
  logic [5:0]  rob_head_tag = 0, Pd_cdb, tag_rob_cdb;

  always #5 clk = ~clk;

  csr_exec_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .busy(busy),
    .ready_awake(ready_awake), .tag_rob_awake(tag_rob_awake), .Conf_awake(Conf_awake),
    .Pj_awake(Pj_awake), .Pd_old_awake(Pd_old_awake), .Pd_awake(Pd_awake),
    .csr_addr_awake(csr_addr_awake), .RegWr_awake(RegWr_awake), .csrWr_awake(csrWr_awake),
    .prf_raddr_j(prf_raddr_j), .prf_raddr_d(prf_raddr_d),
    .prf_rdata_j(prf_rdata_j), .prf_rdata_d(prf_rdata_d),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .rob_head_valid(rob_head_valid), .rob_head_tag(rob_head_tag),
    .ready_cdb(ready_cdb), .RegWr_cdb(RegWr_cdb), .Pd_cdb(Pd_cdb),
    .tag_rob_cdb(tag_rob_cdb), .data_cdb(data_cdb)
  );

  typedef struct {
    logic [3:0] conf; logic csr_wr; logic reg_wr;
    logic [5:0] pj; logic [5:0] pd_old; logic [5:0] pd; logic [5:0] tag;
    logic [13:0] addr; logic [31:0] rj; logic [31:0] rd; logic [31:0] old;
    logic exp_we; logic [31:0] exp_wdata;
  } vec_t;
  typedef struct { logic [13:0] addr; logic [31:0] data; int cyc; } wexp_t;
  typedef struct { logic regwr; logic [5:0] pd; logic [5:0] tag; logic [31:0] data; int cyc; } cexp_t;

  vec_t  tv [9];
  vec_t  cur;
  wexp_t wq [$];
  cexp_t cq [$];
  wexp_t we_e;
  cexp_t cd_e;
  int total = 0, bad = 0, cyc = 0, busy_cnt = 0;

  // register file / CSR file models answer only at the address the instruction names
  assign prf_rdata_j = (prf_raddr_j == cur.pj) ? cur.rj : 32'hBAD0_0001;
  assign prf_rdata_d = (prf_raddr_d == cur.pd_old) ? cur.rd : 32'hBAD0_0002;
  assign csr_rdata   = (csr_raddr == cur.addr) ? cur.old : 32'hBAD0_0003;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (csr_we) begin
      if (wq.size() == 0) chk("spurious_csr_we", 1, 0);
      else begin
        we_e = wq.pop_front();
        chk("we_addr", csr_waddr, we_e.addr);
        chk("we_data", csr_wdata, we_e.data);
        chk("we_cycle", cyc, we_e.cyc);
      end
    end
    if (ready_cdb) begin
      if (cq.size() == 0) chk("spurious_cdb", 1, 0);
      else begin
        cd_e = cq.pop_front();
        chk("cdb_regwr", RegWr_cdb, cd_e.regwr);
        chk("cdb_pd", Pd_cdb, cd_e.pd);
        chk("cdb_tag", tag_rob_cdb, cd_e.tag);
        chk("cdb_data", data_cdb, cd_e.data);
        chk("cdb_cycle", cyc, cd_e.cyc);
      end
    end else chk("cdb_idle_zero", {RegWr_cdb, Pd_cdb, tag_rob_cdb, data_cdb}, 0);
  end

  task automatic drive_awake(input vec_t v);
    tag_rob_awake = v.tag; Conf_awake = v.conf; Pj_awake = v.pj; Pd_old_awake = v.pd_old;
    Pd_awake = v.pd; csr_addr_awake = v.addr; RegWr_awake = v.reg_wr; csrWr_awake = v.csr_wr;
    ready_awake = 1;
  endtask

  // d = cycles after acceptance before the ROB head matches; odd d holds valid low, even d a wrong tag
  task automatic run_txn(input int i, input int d);
    int a, w, n;
    cur = tv[i];
    @(posedge clk); #1;
    a = cyc + 1;
    w = a + ((d + 1 > 2) ? d + 1 : 2);
    if (tv[i].exp_we) wq.push_back('{tv[i].addr, tv[i].exp_wdata, w});
    cq.push_back('{tv[i].reg_wr, tv[i].pd, tv[i].tag, tv[i].old, w + 1});
    drive_awake(tv[i]);
    rob_head_valid = (d == 0) || (d % 2 == 0);
    rob_head_tag   = (d == 0 || d % 2 == 1) ? tv[i].tag : tv[i].tag ^ 6'h1;
    busy_cnt = 0;
    @(posedge clk); #1;
    ready_awake = 0;
    if (d > 0) begin
      repeat (d) @(posedge clk);
      #1;
      rob_head_valid = 1;
      rob_head_tag = tv[i].tag;
    end
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("txn_done", busy, 0);
    chk("busy_cycles", busy_cnt, w - a + 2);
    chk("wq_drained", wq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    rob_head_valid = 0;
  endtask

  initial begin
    tv[0] = '{4'd0, 1'b0, 1'b1, 6'd1,  6'd2,  6'd3,  6'd4,  14'h0006, 32'h0,        32'h0,        32'h0000_1234, 1'b0, 32'h0};
    tv[1] = '{4'd1, 1'b1, 1'b1, 6'd5,  6'd6,  6'd7,  6'd8,  14'h0100, 32'h0,        32'hAAAA_5555, 32'h0000_000F, 1'b1, 32'hAAAA_5555};
    tv[2] = '{4'd2, 1'b1, 1'b1, 6'd9,  6'd10, 6'd11, 6'd12, 14'h0180, 32'h0000_FF00, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_56FF};
    tv[3] = '{4'd0, 1'b1, 1'b1, 6'd13, 6'd14, 6'd15, 6'd16, 14'h0001, 32'h5A5A_5A5A, 32'h3C3C_3C3C, 32'h0BAD_F00D, 1'b0, 32'h0};
    tv[4] = '{4'd7, 1'b1, 1'b0, 6'd17, 6'd18, 6'd19, 6'd20, 14'h0002, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0, 32'h0};
    tv[5] = '{4'd1, 1'b0, 1'b1, 6'd21, 6'd22, 6'd23, 6'd24, 14'h0003, 32'h0,        32'hCAFE_BABE, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tv[6] = '{4'd2, 1'b1, 1'b1, 6'd25, 6'd26, 6'd27, 6'd28, 14'h0020, 32'h0,        32'hFFFF_FFFF, 32'h1357_9BDF, 1'b1, 32'h1357_9BDF};
    tv[7] = '{4'd2, 1'b1, 1'b0, 6'd29, 6'd30, 6'd31, 6'd32, 14'h0021, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0,        1'b1, 32'h0F0F_0F0F};
    tv[8] = '{4'd1, 1'b1, 1'b1, 6'd63, 6'd0,  6'd63, 6'd63, 14'h3FFF, 32'h0,        32'h8765_4321, 32'hFEDC_BA98, 1'b1, 32'h8765_4321};
    cur = tv[0];

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_we", csr_we, 0);
    chk("rst_cdb", {ready_cdb, RegWr_cdb, Pd_cdb, tag_rob_cdb, data_cdb}, 0);
    chk("rst_addr", {prf_raddr_j, prf_raddr_d, csr_raddr, csr_waddr}, 0);
    rst = 1;

    for (int i = 0; i < 9; i++) run_txn(i, 0);
    run_txn(1, 10);
    run_txn(2, 3);

    // flush while the csrwr sits in WRITE
    cur = tv[1];
    @(posedge clk); #1;
    drive_awake(tv[1]);
    rob_head_valid = 1; rob_head_tag = tv[1].tag;
    @(posedge clk); #1;
    ready_awake = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_flush_busy", busy, 1);
    flush = 1;
    #1;
    chk("flush_we", csr_we, 0);
    @(posedge clk); #1;
    flush = 0;
    chk("flush_busy", busy, 0);
    chk("flush_cdb", ready_cdb, 0);
    rob_head_valid = 0;
    repeat (3) @(posedge clk);

    // flush together with ready_awake drops the instruction
    #1;
    drive_awake(tv[2]);
    flush = 1;
    @(posedge clk); #1;
    ready_awake = 0; flush = 0;
    chk("flush_awake_busy", busy, 0);
    repeat (2) @(posedge clk);

    // reset while waiting for commit, then a normal instruction
    cur = tv[2];
    #1;
    drive_awake(tv[2]);
    rob_head_valid = 1; rob_head_tag = tv[2].tag ^ 6'h1;
    @(posedge clk); #1;
    ready_awake = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("wait_busy", busy, 1);
    rst = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_we", csr_we, 0);
    chk("midrst_cdb", {ready_cdb, RegWr_cdb, Pd_cdb, tag_rob_cdb, data_cdb}, 0);
    chk("midrst_addr", {prf_raddr_j, prf_raddr_d, csr_raddr}, 0);
    @(posedge clk); #1;
    rst = 1;
    rob_head_valid = 0;
    run_txn(2, 0);
    repeat (3) @(posedge clk);
    chk("final_wq", wq.size(), 0);
    chk("final_cq", cq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
